uart_receiver: RTL and testbench

UART RX deframer that pairs with the team's UART transmitter and shares its 16x-oversampling Tick from the common baud-rate generator. It synchronizes the asynchronous Rx line, validates the start bit at mid-bit, samples DATA_BITS data bits LSB-first at bit centres, and checks one stop bit. Good bytes go into a holding register with a valid/ack handshake toward the consumer (FIFO or CPU register). Framing errors and overruns are flagged.

---
 rtl/uart_receiver.sv | 121 ++++++++++++
 tb/tb_uart_receiver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART RX deframer on a shared oversampling tick, with valid/ack holding register.
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 Tick,
  input  logic                 Rx,
  input  logic                 RxAck,
  output logic [DATA_BITS-1:0] DataOut,
  output logic                 RxValid,
  output logic                 FrameError,
  output logic                 Overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

  state_t               state;
  logic                 rxMeta;
  logic                 rxSync;
  logic [TW-1:0]        tickCount;
  logic [BW-1:0]        bitCount;
  logic [DATA_BITS-1:0] shiftReg;

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      rxMeta     <= 1'b1;
      rxSync     <= 1'b1;
      state      <= IDLE;
      tickCount  <= '0;
      bitCount   <= '0;
      shiftReg   <= '0;
      DataOut    <= '0;
      RxValid    <= 1'b0;
      FrameError <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      rxMeta     <= Rx;
      rxSync     <= rxMeta;
      FrameError <= 1'b0;
      Overrun    <= 1'b0;
      if (RxAck)
        RxValid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxSync) begin
            state     <= START;
            tickCount <= '0;
          end
        end

        // Start bit must still be low at mid-bit, otherwise it was a glitch.
        START: begin
          if (Tick) begin
            if (tickCount == HALF_LAST) begin
              tickCount <= '0;
              bitCount  <= '0;
              state     <= rxSync ? IDLE : DATA;
            end else begin
              tickCount <= tickCount + TW'(1);
            end
          end
        end

        DATA: begin
          if (Tick) begin
            if (tickCount == FULL_LAST) begin
              tickCount <= '0;
              shiftReg  <= {rxSync, shiftReg[DATA_BITS-1:1]};
              if (bitCount == LAST_BIT)
                state <= STOP;
              else
                bitCount <= bitCount + BW'(1);
            end else begin
              tickCount <= tickCount + TW'(1);
            end
          end
        end

        // An ack on the same edge frees the register, so the new byte lands without overrun.
        STOP: begin
          if (Tick) begin
            if (tickCount == FULL_LAST) begin
              tickCount <= '0;
              if (rxSync) begin
                state <= IDLE;
                if (!RxValid || RxAck) begin
                  DataOut <= shiftReg;
                  RxValid <= 1'b1;
                end else begin
                  Overrun <= 1'b1;
                end
              end else begin
                state      <= RECOVER;
                FrameError <= 1'b1;
              end
            end else begin
              tickCount <= tickCount + TW'(1);
            end
          end
        end

        RECOVER: begin
          if (rxSync)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver: vector table, corner sequences, random frames vs model.
module tb_uart_receiver;
  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int FRAME_CLKS = OVERSAMPLE * (DATA_BITS + 2);
  // clocks from driving the start bit to RxValid: 2 sync + 1 idle detect + half bit + data bits + stop bit
  localparam int LOAD_CLK   = 3 + OVERSAMPLE / 2 + OVERSAMPLE * (DATA_BITS + 1);
  localparam int GAP        = 24;

  logic                 Clock = 1'b0;
  logic                 ResetN = 1'b0;
  logic                 Tick = 1'b1;
  logic                 Rx = 1'b1;
  logic                 RxAck = 1'b0;
  logic [DATA_BITS-1:0] DataOut;
  logic                 RxValid;
  logic                 FrameError;
  logic                 Overrun;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int feHigh = 0;
  int ovHigh = 0;
  int riseCycle = -1;
  logic prevValid = 1'b0;

  uart_receiver #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE)) dut (
    .Clock(Clock), .ResetN(ResetN), .Tick(Tick), .Rx(Rx), .RxAck(RxAck),
    .DataOut(DataOut), .RxValid(RxValid), .FrameError(FrameError), .Overrun(Overrun)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cycle <= cycle + 1;

  always @(negedge Clock) begin
    if (FrameError) feHigh = feHigh + 1;
    if (Overrun) ovHigh = ovHigh + 1;
    if (RxValid && !prevValid) riseCycle = cycle;
    prevValid = RxValid;
  end

  typedef struct {
    logic [DATA_BITS-1:0] data;
    logic                 stopBit;
    bit                   ackAfter;
    logic [DATA_BITS-1:0] expData;
    bit                   expValid;
    int                   expFe;
    int                   expOv;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sendFrame(input logic [DATA_BITS-1:0] d, input logic stopBit,
                           input bit ackAtLoad, output int startCycle);
    logic [DATA_BITS+1:0] bits;
    bits = {stopBit, d, 1'b0};
    startCycle = cycle;
    for (int c = 0; c < FRAME_CLKS; c++) begin
      Rx    = bits[c / OVERSAMPLE];
      RxAck = ackAtLoad && (c == LOAD_CLK - 1);
      @(negedge Clock);
    end
    RxAck = 1'b0;
  endtask

  task automatic idle(input int n);
    Rx = 1'b1;
    repeat (n) @(negedge Clock);
  endtask

  task automatic doAck(input string name);
    RxAck = 1'b1;
    @(negedge Clock);
    RxAck = 1'b0;
    check({name, "_ack_clears"}, int'(RxValid), 0);
  endtask

  task automatic runFrame(input string name, input logic [DATA_BITS-1:0] d, input logic stopBit,
                          input bit ackAfter, input logic [DATA_BITS-1:0] expData,
                          input bit expValid, input int expFe, input int expOv);
    int fe0, ov0, sc;
    fe0 = feHigh;
    ov0 = ovHigh;
    sendFrame(d, stopBit, 1'b0, sc);
    idle(GAP);
    check({name, "_data"}, int'(DataOut), int'(expData));
    check({name, "_valid"}, int'(RxValid), int'(expValid));
    check({name, "_fe"}, feHigh - fe0, expFe);
    check({name, "_ov"}, ovHigh - ov0, expOv);
    if (ackAfter) doAck(name);
  endtask

  initial begin
    int sc, fe0, ov0, rc0;
    bit mValid;
    logic [DATA_BITS-1:0] mData;
    logic [DATA_BITS+1:0] bits;

    vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 0, 0};
    vecs[1] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 0, 0};
    vecs[2] = '{8'h0F, 1'b1, 1'b1, 8'h0F, 1'b1, 0, 0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'h0F, 1'b0, 1, 0};
    vecs[4] = '{8'h7E, 1'b1, 1'b0, 8'h7E, 1'b1, 0, 0};
    vecs[5] = '{8'h99, 1'b1, 1'b0, 8'h7E, 1'b1, 0, 1};
    vecs[6] = '{8'h3C, 1'b0, 1'b1, 8'h7E, 1'b1, 1, 0};
    vecs[7] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 0, 0};

    repeat (4) @(negedge Clock);
    check("reset_data", int'(DataOut), 0);
    check("reset_valid", int'(RxValid), 0);
    check("reset_fe", int'(FrameError), 0);
    check("reset_ov", int'(Overrun), 0);
    ResetN = 1'b1;
    idle(5);

    // first frame: value and exact RxValid latency
    riseCycle = -1;
    fe0 = feHigh;
    ov0 = ovHigh;
    sendFrame(8'h55, 1'b1, 1'b0, sc);
    idle(GAP);
    check("lat_55", riseCycle - sc, LOAD_CLK);
    check("lat_55_data", int'(DataOut), 8'h55);
    check("lat_55_flags", (feHigh - fe0) + (ovHigh - ov0), 0);
    doAck("lat_55");

    for (int i = 0; i < 8; i++)
      runFrame($sformatf("vec%0d", i), vecs[i].data, vecs[i].stopBit, vecs[i].ackAfter,
               vecs[i].expData, vecs[i].expValid, vecs[i].expFe, vecs[i].expOv);

    // short low glitch rejected at the start-bit centre
    fe0 = feHigh;
    ov0 = ovHigh;
    rc0 = riseCycle;
    Rx = 1'b0;
    repeat (4) @(negedge Clock);
    idle(40);
    check("glitch_valid", int'(RxValid), 0);
    check("glitch_rise", riseCycle, rc0);
    check("glitch_flags", (feHigh - fe0) + (ovHigh - ov0), 0);
    runFrame("glitch_81", 8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 0, 0);

    // bad stop bit followed by a long break
    fe0 = feHigh;
    rc0 = riseCycle;
    sendFrame(8'h3C, 1'b0, 1'b0, sc);
    Rx = 1'b0;
    repeat (40 * OVERSAMPLE * (DATA_BITS + 2)) @(negedge Clock);
    check("break_fe", feHigh - fe0, 1);
    check("break_valid", int'(RxValid), 0);
    check("break_rise", riseCycle, rc0);
    idle(GAP);
    runFrame("break_7e", 8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1, 0, 0);

    // overrun, then ack landing exactly on the load edge
    runFrame("ovr_11", 8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 0, 0);
    runFrame("ovr_22", 8'h22, 1'b1, 1'b1, 8'h11, 1'b1, 0, 1);
    runFrame("ackld_11", 8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 0, 0);
    ov0 = ovHigh;
    sendFrame(8'h22, 1'b1, 1'b1, sc);
    idle(GAP);
    check("ackld_22_data", int'(DataOut), 8'h22);
    check("ackld_22_valid", int'(RxValid), 1);
    check("ackld_22_ov", ovHigh - ov0, 0);

    // reset during data bit 4 while a byte is still held
    bits = {1'b1, 8'hC6, 1'b0};
    for (int c = 0; c < 5 * OVERSAMPLE + 8; c++) begin
      Rx = bits[c / OVERSAMPLE];
      @(negedge Clock);
    end
    ResetN = 1'b0;
    Rx = 1'b1;
    repeat (3) @(negedge Clock);
    check("midrst_data", int'(DataOut), 0);
    check("midrst_valid", int'(RxValid), 0);
    check("midrst_flags", int'(FrameError) + int'(Overrun), 0);
    ResetN = 1'b1;
    idle(20);
    runFrame("midrst_c6", 8'hC6, 1'b1, 1'b1, 8'hC6, 1'b1, 0, 0);

    // random frames against a byte-level model of the holding register
    mValid = 1'b0;
    mData  = 8'hC6;
    for (int i = 0; i < 24; i++) begin
      logic [DATA_BITS-1:0] d;
      logic stopOk;
      bit ack;
      int eFe, eOv;
      d      = DATA_BITS'($urandom);
      stopOk = ($urandom_range(0, 4) != 0);
      ack    = bit'($urandom_range(0, 1));
      eFe = 0;
      eOv = 0;
      if (!stopOk) eFe = 1;
      else if (mValid) eOv = 1;
      else begin
        mData  = d;
        mValid = 1'b1;
      end
      runFrame($sformatf("rnd%0d", i), d, stopOk, ack, mData, mValid, eFe, eOv);
      if (ack) mValid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
